// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Top-level controller for the register-file/ALU datapath. Commands
// (op, srcA, srcB, dst, repeat) enter a 2-entry FIFO and are executed one
// at a time through LEER (operand read) and EXEC (write-back) phases.
// A repeat count re-runs the same op with the destination fed back as
// operand A, so a single command can accumulate in place.
//
// Handshake: a command transfers on a rising clk edge where cmdValid and
// cmdReady are both high; cmdReady depends only on registered FIFO occupancy,
// never on cmdValid, and the offered fields must be stable while cmdValid is
// high and cmdReady is low.
module alu_cmd_sequencer #(
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int ITERW         = 4
) (
    input  logic                     clk,
    input  logic                     highRst,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [SELECTIONALU-1:0]  cmdOp,
    input  logic [SELECTIONDECO-1:0] cmdSrcA,
    input  logic [SELECTIONDECO-1:0] cmdSrcB,
    input  logic [SELECTIONDECO-1:0] cmdDst,
    input  logic [ITERW-1:0]         cmdRepeat,
    input  logic                     sOverflow,
    input  logic                     sCarry,
    input  logic                     sNegative,
    input  logic                     sZero,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     busy,
    output logic                     done,
    output logic                     doneErr,
    output logic [3:0]               rFlags,
    output logic [1:0]               dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEER = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [SELECTIONALU-1:0]  op;
        logic [SELECTIONDECO-1:0] src_a;
        logic [SELECTIONDECO-1:0] src_b;
        logic [SELECTIONDECO-1:0] dst;
        logic [ITERW-1:0]         rep;
    } cmd_t;

    localparam logic [SELECTIONDECO-1:0] NOWRITE = '1;
    localparam logic [ITERW-1:0]         ONE     = {{(ITERW-1){1'b0}}, 1'b1};

    // Command FIFO
    cmd_t       fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       push, pop;
    cmd_t       head;
    cmd_t       in_cmd;

    // Working registers
    state_t                   state_q, state_d;
    logic [SELECTIONALU-1:0]  op_q, op_d;
    logic [SELECTIONDECO-1:0] src_a_q, src_a_d;
    logic [SELECTIONDECO-1:0] src_b_q, src_b_d;
    logic [SELECTIONDECO-1:0] dst_q, dst_d;
    logic [ITERW-1:0]         remaining_q, remaining_d;
    logic                     first_q, first_d;
    logic                     done_err_q, done_err_d;
    logic [3:0]               rflags_q, rflags_d;

    assign cmdReady = (count_q != 2'd2);
    assign push     = cmdValid && cmdReady;
    assign pop      = (state_q == IDLE) && (count_q != 2'd0);
    assign head     = fifo_q[rd_ptr_q];
    assign in_cmd   = '{op: cmdOp, src_a: cmdSrcA, src_b: cmdSrcB, dst: cmdDst, rep: cmdRepeat};

    // FIFO occupancy next value; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge highRst) begin
        if (highRst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= in_cmd;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Next-state and working-register updates
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        done_err_d  = done_err_q;
        rflags_d    = rflags_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d        = head.op;
                    src_a_d     = head.src_a;
                    src_b_d     = head.src_b;
                    dst_d       = head.dst;
                    // A compare-only command never writes, so repeating it is pointless
                    remaining_d = (head.dst == NOWRITE) ? '0 : head.rep;
                    first_d     = 1'b1;
                    done_err_d  = 1'b0;
                    state_d     = LEER;
                end
            end
            LEER: begin
                state_d = EXEC;
            end
            EXEC: begin
                rflags_d = {sOverflow, sCarry, sNegative, sZero};
                first_d  = 1'b0;
                if (sOverflow && (remaining_q != '0)) begin
                    done_err_d = 1'b1;
                    state_d    = DONE;
                end else if (remaining_q != '0) begin
                    remaining_d = remaining_q - ONE;
                    state_d     = LEER;
                end else begin
                    done_err_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and working registers
    always_ff @(posedge clk or posedge highRst) begin
        if (highRst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            done_err_q  <= 1'b0;
            rflags_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            done_err_q  <= done_err_d;
            rflags_q    <= rflags_d;
        end
    end

    // Datapath selects decoded from state; C stays NOWRITE outside EXEC
    always_comb begin
        sSelDecoA = '0;
        sSelDecoB = '0;
        sSelDecoC = NOWRITE;
        sSelAlu   = '0;
        case (state_q)
            LEER: begin
                sSelDecoA = first_q ? src_a_q : dst_q;
                sSelDecoB = src_b_q;
                sSelAlu   = op_q;
            end
            EXEC: begin
                sSelDecoA = first_q ? src_a_q : dst_q;
                sSelDecoB = src_b_q;
                sSelDecoC = dst_q;
                sSelAlu   = op_q;
            end
            default: begin
                sSelDecoA = '0;
                sSelDecoB = '0;
                sSelDecoC = NOWRITE;
                sSelAlu   = '0;
            end
        endcase
    end

    assign busy     = (state_q != IDLE) || (count_q != 2'd0);
    assign done     = (state_q == DONE);
    assign doneErr  = done_err_q;
    assign rFlags   = rflags_q;
    assign dbgState = state_q;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven sequencer for the register-file/ALU datapath: accepts operation commands (op, two sources, destination, repeat count) through a valid/ready port, buffers up to two, and drives the A/B read decoders, C write decoder and ALU select through read/execute phases. Repeat counts let one command accumulate in place, e.g. multiply by repeated add. It replaces the fixed single-sum state machine as the datapath's top-level controller.

## Interface
- SELECTIONALU, 3, ALU select width
- SELECTIONDECO, 3, decoder select width; all-ones on C = NOWRITE
- ITERW, 4, repeat-count width
- clk  in  1  clock, rising edge
- highRst  in  1  asynchronous, active-high reset
- cmdValid  in  1  command offered
- cmdReady  out  1  command accepted when cmdValid&&cmdReady at clk edge
- cmdOp  in  SELECTIONALU  ALU operation
- cmdSrcA, cmdSrcB  in  SELECTIONDECO  source registers
- cmdDst  in  SELECTIONDECO  destination; all-ones = compare only, no write
- cmdRepeat  in  ITERW  extra executions after the first (0 = once)
- sOverflow, sCarry, sNegative, sZero  in  1  ALU flags, combinational from current selects
- sSelDecoA, sSelDecoB, sSelDecoC  out  SELECTIONDECO  register-file selects
- sSelAlu  out  SELECTIONALU  ALU select
- busy  out  1  state != IDLE or FIFO not empty
- done  out  1  one-cycle pulse, command finished
- doneErr  out  1  valid with done: terminated early by overflow
- rFlags  out  4  {V,C,N,Z} captured at last EXEC cycle

## Operation
- Reset values: state IDLE, FIFO empty, cmdReady=1, sSelDecoA=0, sSelDecoB=0, sSelDecoC=all-ones, sSelAlu=0, busy=0, done=0, doneErr=0, rFlags=0.
- FIFO: 2 entries; cmdReady = !full (registered count). Push and pop in the same cycle allowed; count unchanged.
- Pop only in IDLE with FIFO non-empty: head loaded into working regs (op, srcA, srcB, dst, remaining=cmdRepeat, first=1), state -> LEER.
- If dst is all-ones, remaining forced to 0 on load.
- Selects are combinational from state and working regs:
  - IDLE: A=0, B=0, C=NOWRITE, ALU=0.
  - LEER: A = first ? srcA : dst, B=srcB, C=NOWRITE, ALU=op.
  - EXEC: same A/B/ALU as LEER, C=dst; register file writes at the edge ending EXEC.
  - DONE: A=0, B=0, C=NOWRITE, ALU=0.
- EXEC edge: rFlags <= {sOverflow,sCarry,sNegative,sZero}; first <= 0.
  - If sOverflow=1 and remaining!=0: -> DONE, doneErr=1.
  - Else if remaining!=0: remaining-1, -> LEER.
  - Else -> DONE, doneErr=0.
- DONE: done=1 for exactly this cycle; doneErr held valid; -> IDLE unconditionally.
- Overflow on the final execution is only reported in rFlags; doneErr stays 0.
- Unsigned remaining counter, no wrap: a decrement only occurs when it is non-zero.

## Timing
- Accept at edge E0 with FIFO empty and IDLE: LEER after E1, EXEC after E2, write at E3, DONE cycle E3–E4, IDLE after E4.
- Single command latency: done 3 cycles after the accept edge. cmdRepeat=N: 3+2N cycles, N+1 writes.
- Back-to-back: second command's LEER starts 1 cycle after the first's DONE (one IDLE cycle).
- A third command stalls: cmdReady=0 while 2 entries are buffered. It is re-accepted the edge after the first pop.
- highRst mid-operation: FIFO and working regs cleared immediately. Selects return to reset values asynchronously (C=NOWRITE), so no write occurs; the in-flight command is dropped without done.

## Test plan
- Reset: assert highRst during EXEC with dst=2 -> C=7 immediately, no write, busy=0, done never pulses, rFlags=0.
- Single add: op=010, A=6, B=7, dst=0, repeat=0 accepted at E0 -> LEER(A=6,B=7,C=7) at E1, EXEC(C=0,ALU=010) at E2, done=1 cycle E3, doneErr=0.
- Repeated add: R6=5, R7=3, dst=6, op=010, repeat=3 -> 4 EXEC cycles; A=6 on first, A=6 (dst) after; done at accept+9; R6 ends 17.
- Overflow stop: repeat=5, flag sOverflow forced 1 on second EXEC -> exactly 2 EXEC cycles, done with doneErr=1, rFlags[3]=1.
- FIFO full: present 3 commands back-to-back while idle -> first two accepted, cmdReady=0 for the third until the first pop edge. All three complete in order, one IDLE cycle between done and the next LEER.
- Compare only: dst=7, repeat=9 -> single EXEC with C=7, rFlags updated, done at accept+3.
